hazard_ctrl: RTL

- Central pipeline hazard sequencer for the 5-stage MIPS core.
- Drives the stall and flush controls: PC write enable, IF/ID write/flush, ID/EX flush.
- Handles load-use hazards, EX-stage redirects (taken branch or jump) and multi-cycle multiply/divide occupancy.
- Sits beside the ID stage. Consumes decoded IF/ID register fields and ID/EX control bits, and feeds the PC, IF/ID and ID/EX registers.

---
 rtl/hazard_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: central pipeline hazard sequencer for the 5-stage MIPS core.
// Produces PC write enable, IF/ID write/flush and ID/EX flush for load-use
// hazards, EX-stage redirects and multiply/divide occupancy.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   if_id_rs/rt(_used)    source register fields of the instruction in ID
//   id_ex_dm_r            instruction in EX is a load
//   id_ex_wr_reg          destination GPR of the instruction in EX
//   ex_redirect           EX resolved a taken branch or jump
//   md_start              EX issues to the multiply/divide unit
//   pc_write              PC update enable
//   if_id_write           IF/ID load enable
//   if_id_flush           IF/ID clear to NOP
//   id_ex_flush           ID/EX clear
//   md_busy               multi-cycle unit occupied
//   hazard_state          current FSM state (0 RUN, 1 LOAD_STALL, 2 MD_WAIT)
//
// Optional build macro HAZARD_STATS_EN adds stall_cycles (32 bits) and
// flush_events (16 bits) event counters.
module hazard_ctrl #(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] if_id_rs,
    input  logic [4:0] if_id_rt,
    input  logic       if_id_rs_used,
    input  logic       if_id_rt_used,
    input  logic       id_ex_dm_r,
    input  logic [4:0] id_ex_wr_reg,
    input  logic       ex_redirect,
    input  logic       md_start,
    output logic       pc_write,
    output logic       if_id_write,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       md_busy,
`ifdef HAZARD_STATS_EN
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_events,
`endif
    output logic [1:0] hazard_state
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_LOAD = 2'd1,
        S_MD   = 2'd2,
        S_BAD  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_LATENCY - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_lu_hit;

    // GPR 0 is hardwired, so a load targeting it never creates a hazard.
    assign w_lu_hit = id_ex_dm_r && (id_ex_wr_reg != 5'd0) &&
                      ((if_id_rs_used && (if_id_rs == id_ex_wr_reg)) ||
                       (if_id_rt_used && (if_id_rt == id_ex_wr_reg)));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next     = S_RUN;
        w_cnt_next = r_cnt;
        case (r_state)
            S_RUN: begin
                if (ex_redirect) begin
                    w_next = S_RUN;
                end else if (md_start) begin
                    w_next     = S_MD;
                    w_cnt_next = MD_LOAD;
                end else if (w_lu_hit) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: w_next = S_RUN;
            S_MD: begin
                // Counter reaching zero marks the last MD_WAIT cycle.
                if (r_cnt == '0) begin
                    w_next = S_RUN;
                end else begin
                    w_next     = S_MD;
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            default: w_next = S_RUN;
        endcase
    end

    // Output logic
    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        md_busy     = 1'b0;
        if (reset) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (ex_redirect) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (md_start || w_lu_hit) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
                // Hazard compare is suppressed: the bubble is already in EX.
                S_LOAD: begin
                    if (ex_redirect) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end
                end
                S_MD: begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                    md_busy     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign hazard_state = r_state;

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [15:0] r_flush_events;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (!pc_write)
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (if_id_flush)
                r_flush_events <= r_flush_events + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;
`endif

endmodule
